// File: rtl/oled_spi_receiver_pkg.sv
// Shared constants and types for the Pmod OLEDrgb serial receiver.
// Panel geometry, RGB565 field layout and shift FSM encoding.
package oled_pkg;

    localparam int unsigned OLED_WIDTH      = 96;
    localparam int unsigned OLED_HEIGHT     = 64;
    localparam int unsigned OLED_NUM_PIXELS = OLED_WIDTH * OLED_HEIGHT;

    localparam int unsigned PIX_IDX_W     = 13;
    localparam int unsigned MAX_PIXELS    = 1 << PIX_IDX_W;
    localparam int unsigned BITS_PER_BYTE = 8;

    localparam int unsigned RGB_RED_HI   = 15;
    localparam int unsigned RGB_RED_LO   = 11;
    localparam int unsigned RGB_GREEN_HI = 10;
    localparam int unsigned RGB_GREEN_LO = 5;
    localparam int unsigned RGB_BLUE_HI  = 4;
    localparam int unsigned RGB_BLUE_LO  = 0;

    typedef logic [PIX_IDX_W-1:0] pix_idx_t;

    typedef struct packed {
        logic [RGB_RED_HI-RGB_RED_LO:0]     red;
        logic [RGB_GREEN_HI-RGB_GREEN_LO:0] green;
        logic [RGB_BLUE_HI-RGB_BLUE_LO:0]   blue;
    } rgb565_t;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/oled_spi_receiver_if.sv
// The seven Pmod OLEDrgb lines as seen between display driver and receiver.
interface oled_spi_if;

    logic cs;
    logic sdin;
    logic sclk;
    logic d_cn;
    logic resn;
    logic vccen;
    logic pmoden;

    modport master (
        output cs, sdin, sclk, d_cn, resn, vccen, pmoden
    );

    modport slave (
        input cs, sdin, sclk, d_cn, resn, vccen, pmoden
    );

endinterface

// File: rtl/oled_spi_receiver_sync_edge.sv
// Multi-flop synchronizer with optional rising/falling edge pulses
// derived from one extra flop behind the synchronized output.
module sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter bit          RESET_VAL = 1'b0,
    parameter bit          EDGE_EN   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    assign dout = sync_q[STAGES-1];

    if (EDGE_EN) begin : g_edge
        logic prev;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev <= RESET_VAL;
            end else begin
                prev <= dout;
            end
        end

        assign rise = dout & ~prev;
        assign fall = ~dout & prev;
    end else begin : g_no_edge
        assign rise = 1'b0;
        assign fall = 1'b0;
    end

endmodule

// File: rtl/oled_spi_receiver.sv
// Oversampling receiver for the Pmod OLEDrgb serial link: decodes command
// bytes and RGB565 pixels, tagging each pixel with its linear index.
module oled_spi_receiver
    import oled_pkg::*;
#(
    parameter int unsigned WIDTH       = OLED_WIDTH,
    parameter int unsigned HEIGHT      = OLED_HEIGHT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clock_100mhz,
    input  logic                 reset_n,
    oled_spi_if.slave            spi,
    output logic [7:0]           cmd_byte,
    output logic                 cmd_valid,
    output logic [15:0]          pixel_data,
    output logic                 pixel_valid,
    output logic [PIX_IDX_W-1:0] pixel_index,
    output logic                 frame_done,
    output logic                 byte_abort,
    output logic                 panel_on
);

    localparam int unsigned NUM_PIX  = WIDTH * HEIGHT;
    localparam pix_idx_t    LAST_IDX = PIX_IDX_W'(NUM_PIX - 1);

    if (NUM_PIX > MAX_PIXELS) begin : g_bad_size
        $error("oled_spi_receiver: WIDTH*HEIGHT exceeds pixel index range");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("oled_spi_receiver: SYNC_STAGES must be at least 2");
    end

    logic       sclk_rise;
    logic       cs_s, sdin_s, d_cn_s, resn_s, vccen_s, pmoden_s;
    logic       unused_sclk_level;
    logic       unused_sclk_fall;
    logic [5:0] unused_rise;
    logic [5:0] unused_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_sclk (
        .clk(clock_100mhz), .rst_n(reset_n), .din(spi.sclk),
        .dout(unused_sclk_level), .rise(sclk_rise), .fall(unused_sclk_fall)
    );

    // cs resets high so the FSM starts deselected
    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGE_EN(1'b0)) u_sync_cs (
        .clk(clock_100mhz), .rst_n(reset_n), .din(spi.cs),
        .dout(cs_s), .rise(unused_rise[0]), .fall(unused_fall[0])
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_sdin (
        .clk(clock_100mhz), .rst_n(reset_n), .din(spi.sdin),
        .dout(sdin_s), .rise(unused_rise[1]), .fall(unused_fall[1])
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_d_cn (
        .clk(clock_100mhz), .rst_n(reset_n), .din(spi.d_cn),
        .dout(d_cn_s), .rise(unused_rise[2]), .fall(unused_fall[2])
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_resn (
        .clk(clock_100mhz), .rst_n(reset_n), .din(spi.resn),
        .dout(resn_s), .rise(unused_rise[3]), .fall(unused_fall[3])
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_vccen (
        .clk(clock_100mhz), .rst_n(reset_n), .din(spi.vccen),
        .dout(vccen_s), .rise(unused_rise[4]), .fall(unused_fall[4])
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_pmoden (
        .clk(clock_100mhz), .rst_n(reset_n), .din(spi.pmoden),
        .dout(pmoden_s), .rise(unused_rise[5]), .fall(unused_fall[5])
    );

    logic [0:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] hi_reg;
    logic       phase_lo;
    pix_idx_t   pixel_counter;

    logic       take_bit;
    logic       byte_done;
    logic [2:0] cnt_next;
    logic [7:0] byte_next;

    // A rise coinciding with cs going high is still shifted in, so the
    // abort decision below sees the post-shift bit count.
    always_comb begin
        take_bit  = sclk_rise && ((state == ST_SHIFT) || !cs_s);
        byte_done = take_bit && (bit_cnt == 3'd7);
        cnt_next  = bit_cnt;
        if (take_bit) begin
            cnt_next = byte_done ? 3'd0 : bit_cnt + 3'd1;
        end
        byte_next = {shift_reg[6:0], sdin_s};
    end

    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            hi_reg        <= '0;
            phase_lo      <= 1'b0;
            pixel_counter <= '0;
            cmd_byte      <= '0;
            cmd_valid     <= 1'b0;
            pixel_data    <= '0;
            pixel_valid   <= 1'b0;
            pixel_index   <= '0;
            frame_done    <= 1'b0;
            byte_abort    <= 1'b0;
        end else if (!resn_s) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            hi_reg        <= '0;
            phase_lo      <= 1'b0;
            pixel_counter <= '0;
            cmd_byte      <= '0;
            cmd_valid     <= 1'b0;
            pixel_data    <= '0;
            pixel_valid   <= 1'b0;
            pixel_index   <= '0;
            frame_done    <= 1'b0;
            byte_abort    <= 1'b0;
        end else begin
            cmd_valid   <= 1'b0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            byte_abort  <= 1'b0;

            if (take_bit) begin
                state     <= ST_SHIFT;
                shift_reg <= byte_next;
                bit_cnt   <= cnt_next;
            end

            if (byte_done) begin
                if (!d_cn_s) begin
                    cmd_byte      <= byte_next;
                    cmd_valid     <= 1'b1;
                    phase_lo      <= 1'b0;
                    pixel_counter <= '0;
                end else if (!phase_lo) begin
                    hi_reg   <= byte_next;
                    phase_lo <= 1'b1;
                end else begin
                    pixel_data  <= {hi_reg, byte_next};
                    pixel_index <= pixel_counter;
                    pixel_valid <= 1'b1;
                    phase_lo    <= 1'b0;
                    if (pixel_counter == LAST_IDX) begin
                        frame_done    <= 1'b1;
                        pixel_counter <= '0;
                    end else begin
                        pixel_counter <= pixel_counter + PIX_IDX_W'(1);
                    end
                end
            end

            if (cs_s && (state == ST_SHIFT)) begin
                state      <= ST_IDLE;
                bit_cnt    <= '0;
                byte_abort <= (cnt_next != 3'd0);
            end
        end
    end

    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            panel_on <= 1'b0;
        end else begin
            panel_on <= vccen_s & pmoden_s;
        end
    end

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Randomized self-checking bench for oled_spi_receiver against a byte-level
// scoreboard that predicts each output pulse and its exact cycle.
module tb_oled_spi_receiver;
    import oled_pkg::*;

    localparam int unsigned TB_W = 8;
    localparam int unsigned TB_H = 4;
    localparam int NPIX = TB_W * TB_H;
    localparam int S    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    oled_spi_if spi();

    logic [7:0]           cmd_byte;
    logic                 cmd_valid;
    logic [15:0]          pixel_data;
    logic                 pixel_valid;
    logic [PIX_IDX_W-1:0] pixel_index;
    logic                 frame_done;
    logic                 byte_abort;
    logic                 panel_on;

    oled_spi_receiver #(.WIDTH(TB_W), .HEIGHT(TB_H), .SYNC_STAGES(S)) dut (
        .clock_100mhz(clk),
        .reset_n(rst_n),
        .spi(spi),
        .cmd_byte(cmd_byte),
        .cmd_valid(cmd_valid),
        .pixel_data(pixel_data),
        .pixel_valid(pixel_valid),
        .pixel_index(pixel_index),
        .frame_done(frame_done),
        .byte_abort(byte_abort),
        .panel_on(panel_on)
    );

    typedef struct {
        int          due;
        int          kind;   // 0 command, 1 pixel, 2 abort
        logic [15:0] data;
        int          idx;
        bit          fd;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    bit  check_en = 1'b0;

    bit          m_phase_lo;
    logic [7:0]  m_hi;
    int          m_cnt;
    logic [7:0]  m_cmd;
    logic [15:0] m_pix;
    logic [12:0] m_idx;

    int cv_seen = 0, pv_seen = 0, ab_seen = 0, fd_seen = 0, fd_last_idx = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase_lo = 1'b0;
        m_hi = '0;
        m_cnt = 0;
        m_cmd = '0;
        m_pix = '0;
        m_idx = '0;
        q.delete();
    endtask

    task automatic model_byte(input logic dcn, input logic [7:0] b, input int due);
        ev_t e;
        e.due = due; e.data = '0; e.idx = 0; e.fd = 1'b0;
        if (!dcn) begin
            e.kind = 0;
            e.data = {8'h00, b};
            q.push_back(e);
            m_phase_lo = 1'b0;
            m_cnt = 0;
        end else if (!m_phase_lo) begin
            m_hi = b;
            m_phase_lo = 1'b1;
        end else begin
            e.kind = 1;
            e.data = {m_hi, b};
            e.idx = m_cnt;
            e.fd = (m_cnt == NPIX - 1);
            q.push_back(e);
            m_cnt = (m_cnt + 1) % NPIX;
            m_phase_lo = 1'b0;
        end
    endtask

    task automatic model_abort(input int due);
        ev_t e;
        e.due = due; e.kind = 2; e.data = '0; e.idx = 0; e.fd = 1'b0;
        q.push_back(e);
    endtask

    // Per-cycle scoreboard: pulses must appear exactly on their due cycle.
    ev_t cur;
    always @(negedge clk) begin
        if (check_en) begin
            logic e_cv, e_pv, e_fd, e_ab;
            e_cv = 1'b0; e_pv = 1'b0; e_fd = 1'b0; e_ab = 1'b0;
            while (q.size() > 0 && q[0].due < cyc) begin
                check("missed_event_due", 64'(q[0].due), 64'(cyc));
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                cur = q.pop_front();
                case (cur.kind)
                    0: begin e_cv = 1'b1; m_cmd = cur.data[7:0]; end
                    1: begin e_pv = 1'b1; e_fd = cur.fd; m_pix = cur.data; m_idx = 13'(cur.idx); end
                    default: e_ab = 1'b1;
                endcase
            end
            check("pulses{cv,pv,fd,ab}", 64'({cmd_valid, pixel_valid, frame_done, byte_abort}),
                  64'({e_cv, e_pv, e_fd, e_ab}));
            check("held{cmd,pix,idx}", 64'({cmd_byte, pixel_data, pixel_index}),
                  64'({m_cmd, m_pix, m_idx}));
            check("valid_exclusive", 64'(cmd_valid & pixel_valid), 64'(0));
            if (cmd_valid) cv_seen++;
            if (pixel_valid) pv_seen++;
            if (byte_abort) ab_seen++;
            if (frame_done) begin
                fd_seen++;
                fd_last_idx = int'(pixel_index);
            end
        end
    end

    task automatic send_bits(input logic [7:0] b, input logic dcn, input int nbits,
                             input bit cs_with_last, input bit cs_after);
        int last_rise;
        last_rise = 0;
        if (spi.cs) begin
            @(posedge clk); #1 spi.cs = 1'b0;
        end
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1;
            spi.sclk = 1'b0; spi.sdin = b[7-i]; spi.d_cn = dcn;
            repeat (2) @(posedge clk);
            @(posedge clk); #1;
            spi.sclk = 1'b1;
            if (cs_with_last && i == nbits - 1) spi.cs = 1'b1;
            last_rise = cyc;
            repeat (2) @(posedge clk);
        end
        if (nbits == 8) model_byte(dcn, b, last_rise + 1 + S);
        else if (cs_with_last) model_abort(last_rise + 1 + S);
        @(posedge clk); #1 spi.sclk = 1'b0;
        if (cs_after && !cs_with_last) begin
            spi.cs = 1'b1;
            if (nbits < 8) model_abort(cyc + 1 + S);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("drain_queue_empty", 64'(q.size()), 64'(0));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, p0, a0, f0;
        spi.cs = 1'b1; spi.sdin = 1'b0; spi.sclk = 1'b0; spi.d_cn = 1'b0;
        spi.resn = 1'b1; spi.vccen = 1'b1; spi.pmoden = 1'b1;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_valid", 64'(cmd_valid), 64'(0));
        check("reset_pixel_valid", 64'(pixel_valid), 64'(0));
        check("reset_pixel_index", 64'(pixel_index), 64'(0));
        check("reset_panel_on", 64'(panel_on), 64'(0));
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("panel_on_after_reset", 64'(panel_on), 64'(1));
        check_en = 1'b1;

        // Command 0xAF
        c0 = cv_seen; p0 = pv_seen;
        send_bits(8'hAF, 1'b0, 8, 1'b0, 1'b1);
        drain();
        check("cmd_AF_byte", 64'(cmd_byte), 64'(8'hAF));
        check("cmd_AF_pulses", 64'(cv_seen - c0), 64'(1));
        check("cmd_AF_no_pixel", 64'(pv_seen - p0), 64'(0));

        // Pixel pairs
        send_bits(8'hF8, 1'b1, 8, 1'b0, 1'b0);
        send_bits(8'h00, 1'b1, 8, 1'b0, 1'b1);
        drain();
        check("pix_F800_data", 64'(pixel_data), 64'(16'hF800));
        check("pix_F800_index", 64'(pixel_index), 64'(0));
        send_bits(8'h12, 1'b1, 8, 1'b0, 1'b0);
        send_bits(8'h34, 1'b1, 8, 1'b0, 1'b0);
        drain();
        check("pix_1234_data", 64'(pixel_data), 64'(16'h1234));
        check("pix_1234_index", 64'(pixel_index), 64'(1));

        // Full frame with cs toggled per byte, then wrap
        send_bits(8'h15, 1'b0, 8, 1'b0, 1'b1);
        f0 = fd_seen;
        for (int i = 0; i < NPIX; i++) begin
            send_bits(8'($urandom), 1'b1, 8, 1'b0, 1'b1);
            send_bits(8'($urandom), 1'b1, 8, 1'b0, 1'b1);
        end
        drain();
        check("frame_done_count", 64'(fd_seen - f0), 64'(1));
        check("frame_done_index", 64'(fd_last_idx), 64'(NPIX - 1));
        send_bits(8'hAB, 1'b1, 8, 1'b0, 1'b1);
        send_bits(8'hCD, 1'b1, 8, 1'b0, 1'b1);
        drain();
        check("wrap_index", 64'(pixel_index), 64'(0));
        check("wrap_data", 64'(pixel_data), 64'(16'hABCD));

        // Abort after 5 bits, then a clean command
        a0 = ab_seen;
        send_bits(8'hFF, 1'b0, 5, 1'b0, 1'b1);
        send_bits(8'h5A, 1'b0, 8, 1'b0, 1'b1);
        drain();
        check("abort_count", 64'(ab_seen - a0), 64'(1));
        check("after_abort_cmd", 64'(cmd_byte), 64'(8'h5A));

        // cs rising together with a rise: 8th bit completes, 3rd bit aborts
        a0 = ab_seen;
        send_bits(8'hC3, 1'b0, 8, 1'b1, 1'b0);
        drain();
        check("simul_complete_cmd", 64'(cmd_byte), 64'(8'hC3));
        check("simul_complete_no_abort", 64'(ab_seen - a0), 64'(0));
        send_bits(8'h00, 1'b1, 3, 1'b1, 1'b0);
        drain();
        check("simul_abort_count", 64'(ab_seen - a0), 64'(1));

        // Orphan HI byte discarded by a command
        send_bits(8'h12, 1'b1, 8, 1'b0, 1'b0);
        send_bits(8'hA0, 1'b0, 8, 1'b0, 1'b0);
        send_bits(8'h07, 1'b1, 8, 1'b0, 1'b0);
        send_bits(8'hE0, 1'b1, 8, 1'b0, 1'b1);
        drain();
        check("orphan_cmd", 64'(cmd_byte), 64'(8'hA0));
        check("orphan_pix_data", 64'(pixel_data), 64'(16'h07E0));
        check("orphan_pix_index", 64'(pixel_index), 64'(0));

        // Leave a HI byte pending, then panel reset via resn
        send_bits(8'h99, 1'b1, 8, 1'b0, 1'b1);
        drain();
        check_en = 1'b0;
        @(posedge clk); #1 spi.resn = 1'b0;
        repeat (3) @(posedge clk);
        #1 spi.pmoden = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("resn_cmd_byte", 64'(cmd_byte), 64'(0));
        check("resn_pixel_data", 64'(pixel_data), 64'(0));
        check("resn_pixel_index", 64'(pixel_index), 64'(0));
        check("resn_panel_on_tracks", 64'(panel_on), 64'(0));
        spi.resn = 1'b1; spi.pmoden = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("resn_panel_on_back", 64'(panel_on), 64'(1));
        model_reset();
        check_en = 1'b1;
        send_bits(8'h5C, 1'b1, 8, 1'b0, 1'b0);
        send_bits(8'h3E, 1'b1, 8, 1'b0, 1'b1);
        drain();
        check("post_resn_pix", 64'({pixel_data, pixel_index}), 64'({16'h5C3E, 13'd0}));

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            int r;
            logic [7:0] b;
            logic dcn;
            r = $urandom_range(0, 9);
            b = 8'($urandom);
            dcn = ($urandom_range(0, 9) < 7);
            if (r == 0) send_bits(b, dcn, $urandom_range(1, 7), 1'b0, 1'b1);
            else if (r == 1) send_bits(b, dcn, $urandom_range(1, 8), 1'b1, 1'b0);
            else send_bits(b, dcn, 8, 1'b0, 1'($urandom_range(0, 1)));
        end
        drain();

        // reset_n mid-byte
        send_bits(8'hFF, 1'b1, 4, 1'b0, 1'b0);
        check_en = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("midbyte_reset_outputs",
              64'({cmd_valid, pixel_valid, frame_done, byte_abort, panel_on}), 64'(0));
        check("midbyte_reset_held", 64'({cmd_byte, pixel_data, pixel_index}), 64'(0));
        spi.cs = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        check_en = 1'b1;
        send_bits(8'h81, 1'b1, 8, 1'b0, 1'b0);
        send_bits(8'h42, 1'b1, 8, 1'b0, 1'b1);
        drain();
        check("after_reset_pix", 64'({pixel_data, pixel_index}), 64'({16'h8142, 13'd0}));

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
